// File: rtl/elite_spi_disp_rx.sv
// elite_spi_disp_rx
//   SPI mode-0 slave that takes display commands from the HPS and drives the
//   Elite_7Seg_Disp_Word / Elite_7Seg_Set_Flag inputs of the 7-seg block.
//   The SPI pins are synchronised into the CLOCK_50 domain. 16-bit frames
//   {opcode, data} are deframed: CMD_SET loads the data byte and pulses
//   Set_Flag, CMD_NOP is ignored, and any other opcode or a truncated frame
//   pulses Frame_Err and bumps a saturating error counter.
//
// Ports
//   CLOCK_50              in   system clock
//   Reset_Spi             in   synchronous active-high reset
//   SPI_SCLK/CS_N/MOSI    in   asynchronous SPI pins (mode 0, MSB first)
//   SPI_MISO              out  echo of Disp_Word, or tied low
//   Elite_7Seg_Disp_Word  out  last data byte written with CMD_SET
//   Elite_7Seg_Set_Flag   out  one-cycle pulse when Disp_Word is updated
//   Frame_Err             out  one-cycle pulse on bad opcode or truncated frame
//   Err_Count             out  saturating count of Frame_Err pulses
//
// Build option
//   ELITE_SPI_ECHO_EN : when defined, MISO shifts out Disp_Word (MSB first)
//   during bits 8..15 of every frame; otherwise MISO is constant 0.
//
// state  | meaning
// IDLE   | chip select high, bit counter held at zero
// SHIFT  | chip select low, sampling MOSI on SCLK rising edges

module elite_spi_disp_rx #(
    parameter logic [7:0]  CMD_SET     = 8'h01,
    parameter logic [7:0]  CMD_NOP     = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLOCK_50,
    input  logic       Reset_Spi,
    input  logic       SPI_SCLK,
    input  logic       SPI_CS_N,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic [7:0] Elite_7Seg_Disp_Word,
    output logic       Elite_7Seg_Set_Flag,
    output logic       Frame_Err,
    output logic [7:0] Err_Count
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall;

    logic        state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  disp_word_q, disp_word_d;
    logic        set_flag_q, set_flag_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        err_trunc, err_opcode;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_ff @(posedge CLOCK_50) begin
        if (Reset_Spi) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;   // deselected until the pin says otherwise
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        disp_word_d  = disp_word_q;
        set_flag_d   = 1'b0;
        frame_err_d  = 1'b0;
        err_cnt_d    = err_cnt_q;
        err_trunc    = 1'b0;
        err_opcode   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 4'd0;
                if (!cs_s) state_d = ST_SHIFT;
            end
            default: begin
                // A rising edge coincident with deselect is dropped.
                if (cs_s) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                    err_trunc = (bit_cnt_q != 4'd0);
                end else if (sclk_rise) begin
                    shift_d      = {shift_q[14:0], mosi_s};
                    bit_cnt_d    = bit_cnt_q + 4'd1;
                    frame_done_d = (bit_cnt_q == 4'd15);
                end
            end
        endcase

        // Decode one cycle after the counter wraps; the counter is zero then,
        // so a truncation error cannot coincide with a decode.
        if (frame_done_q) begin
            if (shift_q[15:8] == CMD_SET) begin
                disp_word_d = shift_q[7:0];
                set_flag_d  = 1'b1;
            end else if (shift_q[15:8] != CMD_NOP) begin
                err_opcode = 1'b1;
            end
        end

        if (err_trunc || err_opcode) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset_Spi) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 16'h0000;
            frame_done_q <= 1'b0;
            disp_word_q  <= 8'h00;
            set_flag_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            frame_done_q <= frame_done_d;
            disp_word_q  <= disp_word_d;
            set_flag_q   <= set_flag_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

`ifdef ELITE_SPI_ECHO_EN
    logic [7:0] echo_sr_q, echo_sr_d;
    logic       miso_q, miso_d;

    // Falling edge after the 8th rise loads the echo word; the master samples
    // each echoed bit on the following rising edge.
    always_comb begin
        echo_sr_d = echo_sr_q;
        miso_d    = miso_q;
        if (state_q == ST_IDLE || cs_s) begin
            miso_d = 1'b0;
        end else if (sclk_fall) begin
            if (bit_cnt_q == 4'd8) begin
                miso_d    = disp_word_q[7];
                echo_sr_d = {disp_word_q[6:0], 1'b0};
            end else if (bit_cnt_q[3]) begin
                miso_d    = echo_sr_q[7];
                echo_sr_d = {echo_sr_q[6:0], 1'b0};
            end else begin
                miso_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset_Spi) begin
            echo_sr_q <= 8'h00;
            miso_q    <= 1'b0;
        end else begin
            echo_sr_q <= echo_sr_d;
            miso_q    <= miso_d;
        end
    end

    assign SPI_MISO = miso_q;
`else
    assign SPI_MISO = 1'b0;
`endif

    assign Elite_7Seg_Disp_Word = disp_word_q;
    assign Elite_7Seg_Set_Flag  = set_flag_q;
    assign Frame_Err            = frame_err_q;
    assign Err_Count            = err_cnt_q;

endmodule
